// File: rtl/td4_input_port_if.sv
// Signal bundle between the TD4 switch conditioner and its environment.
// tick is a one-cycle strobe with no handshake: the port captures on every cycle it is high.
interface td4_input_port_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] sw_raw;
    logic             tick;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] sw_stable;
    logic             changed;

    modport master (
        output sw_raw,
        output tick,
        input  in_data,
        input  sw_stable,
        input  changed
    );

    modport slave (
        input  sw_raw,
        input  tick,
        output in_data,
        output sw_stable,
        output changed
    );
endinterface

// File: rtl/td4_input_port.sv
// TD4 IN port: 2-flop synchronizer, per-bit debounce, instruction-aligned capture.
// Optional TD4_IN_STICKY_EN keeps short presses visible until the next tick.
module td4_input_port #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic              clk,
    input  logic              rst,
    td4_input_port_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] upd;
    logic [WIDTH-1:0] in_q;
    logic [WIDTH-1:0] capture;
    logic             changed_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // A bit is accepted only after s2 disagrees with it for DEBOUNCE_CYCLES edges in a row.
    always_comb begin
        upd      = '0;
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    upd[i]      = 1'b1;
                    stable_d[i] = s2[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

`ifdef TD4_IN_STICKY_EN
    logic [WIDTH-1:0] sticky_q;
    logic [WIDTH-1:0] rise;

    assign rise    = upd & ~stable_q;
    assign capture = stable_q | sticky_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= (sticky_q & ~{WIDTH{bus.tick}}) | rise;
        end
    end
`else
    assign capture = stable_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
            stable_q  <= '0;
            in_q      <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1        <= bus.sw_raw;
            s2        <= s1;
            stable_q  <= stable_d;
            changed_q <= |upd;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            // Capture uses the pre-edge debounced value, so a same-edge update waits one tick.
            if (bus.tick) begin
                in_q <= capture;
            end
        end
    end

    assign bus.in_data   = in_q;
    assign bus.sw_stable = stable_q;
    assign bus.changed   = changed_q;
endmodule

// File: tb/tb_td4_input_port.sv
// Bench for td4_input_port with D=4: directed scenarios then randomized switch activity,
// checked against a history-window reference model.
module tb_td4_input_port;
  localparam int W = 4;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  td4_input_port_if #(.WIDTH(W)) bus ();

  td4_input_port #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];

  // reference model state
  logic [W-1:0] m_s1, m_s2, m_stable, m_sticky, m_in;
  logic m_changed;
  logic [W-1:0] s2_hist[$];
  int ecnt;
  int last_upd[W];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_sticky = '0; m_in = '0; m_changed = 1'b0;
    s2_hist.delete();
    exp_q.delete();
    ecnt = 0;
    foreach (last_upd[i]) last_upd[i] = 0;
  endfunction

  // A bit flips when the last D synchronized samples all disagree with it
  // and no flip of that bit happened inside that window.
  function automatic void model_edge(input logic [W-1:0] raw, input logic tk);
    logic [W-1:0] upd;
    logic [W-1:0] nstable;
    upd = '0;
    ecnt++;
    s2_hist.push_back(m_s2);
    nstable = m_stable;
    for (int i = 0; i < W; i++) begin
      if (ecnt - last_upd[i] >= D) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int k = 0; k < D; k++)
          if (s2_hist[ecnt - 1 - k][i] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) begin
          upd[i] = 1'b1;
          nstable[i] = ~m_stable[i];
          last_upd[i] = ecnt;
        end
      end
    end
`ifdef TD4_IN_STICKY_EN
    if (tk) m_in = m_stable | m_sticky;
    m_sticky = (tk ? '0 : m_sticky) | (upd & nstable);
`else
    if (tk) m_in = m_stable;
`endif
    m_changed = |upd;
    m_stable = nstable;
    m_s2 = m_s1;
    m_s1 = raw;
  endfunction

  // driver tasks
  task automatic step(input logic [W-1:0] raw, input logic tk);
    @(negedge clk);
    bus.sw_raw = raw;
    bus.tick = tk;
    @(posedge clk);
    model_edge(raw, tk);
    exp_q.push_back(m_in);
    cyc++;
    #1;
    check("sw_stable", bus.sw_stable, m_stable);
    check("changed", {{(W-1){1'b0}}, bus.changed}, {{(W-1){1'b0}}, m_changed});
    check("in_data", bus.in_data, exp_q.pop_front());
  endtask

  task automatic idle(input logic [W-1:0] raw, input int n);
    for (int k = 0; k < n; k++) step(raw, 1'b0);
  endtask

  // Called right after a step: pulses reset between edges.
  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1;
    check("async_rst_in_data", bus.in_data, '0);
    check("async_rst_sw_stable", bus.sw_stable, '0);
    check("async_rst_changed", {{(W-1){1'b0}}, bus.changed}, '0);
    #1 rst = 1'b0;
    model_reset();
  endtask

  logic [W-1:0] r;
  logic [W-1:0] sticky_exp;

  initial begin
    bus.sw_raw = 4'b1111;
    bus.tick = 1'b0;
    model_reset();
`ifdef TD4_IN_STICKY_EN
    sticky_exp = 4'b0100;
`else
    sticky_exp = 4'b0000;
`endif

    // 1: reset takes effect with no clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_in_data", bus.in_data, '0);
    check("rst_sw_stable", bus.sw_stable, '0);
    check("rst_changed", {{(W-1){1'b0}}, bus.changed}, '0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_held_sw_stable", bus.sw_stable, '0);
    bus.sw_raw = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // 2: clean change
    for (int e = 1; e <= 7; e++) begin
      step(4'b0101, 1'b0);
      if (e == 5) check("t2_before_edge6", bus.sw_stable, 4'b0000);
      if (e == 6) begin
        check("t2_edge6_stable", bus.sw_stable, 4'b0101);
        check("t2_edge6_changed", {{(W-1){1'b0}}, bus.changed}, 4'b0001);
      end
      if (e == 7) begin
        check("t2_changed_one_cycle", {{(W-1){1'b0}}, bus.changed}, 4'b0000);
        check("t2_in_data_hold", bus.in_data, 4'b0000);
      end
    end
    step(4'b0101, 1'b1);
    check("t2_in_data_tick", bus.in_data, 4'b0101);
    idle(4'b0000, 8);

    // 3: bounce rejected, then a 5-cycle hold accepted
    idle(4'b0001, 3);
    idle(4'b0000, 8);
    check("t3_bounce_rejected", bus.sw_stable, 4'b0000);
    for (int e = 1; e <= 6; e++) begin
      step((e <= 5) ? 4'b0001 : 4'b0000, 1'b0);
      if (e == 6) begin
        check("t3_accept_stable", bus.sw_stable, 4'b0001);
        check("t3_accept_changed", {{(W-1){1'b0}}, bus.changed}, 4'b0001);
      end
    end
    idle(4'b0000, 8);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    check("t3_held_tick_in_data", bus.in_data, 4'b0000);

    // 4: tick on the same edge as an update captures the old value
    for (int e = 1; e <= 6; e++) begin
      step(4'b0011, e == 6);
      if (e == 6) begin
        check("t4_collision_in_data", bus.in_data, 4'b0000);
        check("t4_collision_stable", bus.sw_stable, 4'b0011);
      end
    end
    idle(4'b0011, 3);
    step(4'b0011, 1'b1);
    check("t4_next_tick_in_data", bus.in_data, 4'b0011);

    // 5: reset mid-count discards progress
    idle(4'b0000, 8);
    idle(4'b1000, 4);
    pulse_reset();
    for (int e = 1; e <= 6; e++) begin
      step(4'b1000, 1'b0);
      if (e == 5) check("t5_edge5_stable", bus.sw_stable, 4'b0000);
      if (e == 6) check("t5_edge6_stable", bus.sw_stable, 4'b1000);
    end

    // 6: short press between ticks
    idle(4'b0000, 8);
    step(4'b0000, 1'b1);
    for (int e = 1; e <= 15; e++) step((e <= 8) ? 4'b0100 : 4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    check("t6_first_tick", bus.in_data, sticky_exp);
    idle(4'b0000, 15);
    step(4'b0000, 1'b1);
    check("t6_second_tick", bus.in_data, 4'b0000);

    // randomized switch activity with a periodic tick
    r = '0;
    for (int n = 0; n < 800; n++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      step(r, (cyc % 16) == 15);
      if ($urandom_range(0, 199) == 0) pulse_reset();
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
